// File: rtl/timer_ssms_display_if.sv
// Bus between the stopwatch timer (master) and the sss.mmm display reader (slave).
// Carries the time request/value, the converted BCD word with its status,
// and the multiplexed 7-segment pin drive.
interface timer_ssms_display_if;
  logic        time_1ms;
  logic [19:0] t;
  logic [23:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        ovf;
  logic [5:0]  dig_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  modport master (
    output time_1ms, t,
    input  bcd, bcd_valid, busy, ovf, dig_n, seg_n, dp_n
  );

  modport slave (
    input  time_1ms, t,
    output bcd, bcd_valid, busy, ovf, dig_n, seg_n, dp_n
  );
endinterface

// File: rtl/timer_ssms_display.sv
// Stopwatch display reader: synchronises the 1 ms strobe, converts the
// millisecond count to six BCD digits with a sequential double-dabble, and
// scans them onto a 6-digit active-low 7-segment display as sss.mmm.
module timer_ssms_display #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1,
  parameter int T_MAX    = 999999
) (
  input  logic                 clk,
  input  logic                 KEY2,
  timer_ssms_display_if.slave  bus
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [19:0]      T_MAX_V  = 20'(T_MAX);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         sync;
  logic               req;
  logic               pending;
  logic [4:0]         shift_cnt;
  logic [43:0]        sreg;
  logic               capture;
  logic               shift_en;
  logic               finish;
  logic [DIV_W-1:0]   div;
  logic [2:0]         idx;
  logic [3:0]         nib;
  logic               blank;
  logic [23:0]        bcd_r;
  logic               bcd_valid_r;
  logic               busy_r;
  logic               ovf_r;
  logic [5:0]         dig_n_r;
  logic [6:0]         seg_n_r;
  logic               dp_n_r;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [43:0] dabble_step(input logic [43:0] v);
    logic [43:0] a;
    a = v;
    for (int i = 0; i < 6; i++) begin
      if (a[20+4*i +: 4] >= 4'd5)
        a[20+4*i +: 4] = a[20+4*i +: 4] + 4'd3;
    end
    return {a[42:0], 1'b0};
  endfunction

  // Active-low gfedcba pattern; anything outside 0..9 is shown dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Two-flop synchroniser on the strobe, then a registered rising-edge pulse.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      sync <= 3'b000;
      req  <= 1'b0;
    end else begin
      sync <= {sync[1:0], bus.time_1ms};
      req  <= sync[1] & ~sync[2];
    end
  end

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) state <= IDLE;
    else       state <= state_nxt;
  end

  // Conversion FSM next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (req || pending) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (shift_cnt == 5'd19) state_nxt = DONE;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-deep request memory for strobes arriving while a conversion runs.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2)                          pending <= 1'b0;
    else if (capture)                   pending <= 1'b0;
    else if (req && (state != IDLE))    pending <= 1'b1;
  end

  // Shift register and step counter for the double-dabble.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      sreg      <= '0;
      shift_cnt <= '0;
    end else if (capture) begin
      sreg      <= {24'd0, (bus.t > T_MAX_V) ? T_MAX_V : bus.t};
      shift_cnt <= '0;
    end else if (shift_en) begin
      sreg      <= dabble_step(sreg);
      shift_cnt <= shift_cnt + 5'd1;
    end
  end

  // Result word and status: bcd only changes atomically at the end.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      bcd_r       <= '0;
      bcd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      bcd_valid_r <= finish;
      if (capture) begin
        busy_r <= 1'b1;
        ovf_r  <= (bus.t > T_MAX_V);
      end
      if (finish) begin
        busy_r <= 1'b0;
        bcd_r  <= sreg[43:20];
      end
    end
  end

  // Free-running scan divider and digit index.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Pick the digit under scan and decide leading-zero blanking.
  always_comb begin
    nib   = 4'd0;
    blank = 1'b0;
    case (idx)
      3'd0: nib = bcd_r[3:0];
      3'd1: nib = bcd_r[7:4];
      3'd2: nib = bcd_r[11:8];
      3'd3: nib = bcd_r[15:12];
      3'd4: nib = bcd_r[19:16];
      3'd5: nib = bcd_r[23:20];
      default: nib = 4'd0;
    endcase
    if (BLANK_LZ != 0) begin
      if ((idx == 3'd5) && (bcd_r[23:20] == 4'd0))  blank = 1'b1;
      if ((idx == 3'd4) && (bcd_r[23:16] == 8'd0))  blank = 1'b1;
    end
  end

  // Display pins registered together; divider==0 is an all-off guard cycle.
  always_ff @(posedge clk or negedge KEY2) begin
    if (!KEY2) begin
      dig_n_r <= 6'h3F;
      seg_n_r <= 7'h7F;
      dp_n_r  <= 1'b1;
    end else if (div == '0) begin
      dig_n_r <= 6'h3F;
      seg_n_r <= 7'h7F;
      dp_n_r  <= 1'b1;
    end else begin
      dig_n_r <= ~(6'd1 << idx);
      seg_n_r <= blank ? 7'h7F : seg_code(nib);
      dp_n_r  <= (idx != 3'd3);
    end
  end

  assign bus.bcd       = bcd_r;
  assign bus.bcd_valid = bcd_valid_r;
  assign bus.busy      = busy_r;
  assign bus.ovf       = ovf_r;
  assign bus.dig_n     = dig_n_r;
  assign bus.seg_n     = seg_n_r;
  assign bus.dp_n      = dp_n_r;

endmodule

// File: doc/timer_ssms_display.md
Name: timer_ssms_display

Overview:
- Reader/display end of the stopwatch time bus: consumes the 20-bit millisecond count `t` (range 0..999999) produced by the stopwatch timer.
- Converts `t` sequentially (double-dabble) into six BCD digits in sss.mmm form.
- Drives a 6-digit multiplexed, active-low 7-segment display with the decimal point after the seconds units digit.
- Sits between the timer and the board HEX pins; also exports the BCD word for other consumers.

Parameters:
- SCAN_DIV, 50000, clocks each digit stays selected (1 kHz per digit at 50 MHz); minimum 2.
- BLANK_LZ, 1, when 1 blank leading zeros of seconds hundreds/tens digits.
- T_MAX, 999999, largest displayable count; larger inputs clamp.

Ports:
- clk  in  1  system clock
- KEY2  in  1  asynchronous active-low reset
- time_1ms  in  1  1 ms strobe from timer domain, asynchronous to clk, requests an update
- t  in  20  time value in ms, stable around time_1ms rising edge
- bcd  out  24  {s100,s10,s1,ms100,ms10,ms1}, one nibble each
- bcd_valid  out  1  one-clock pulse when bcd updates
- busy  out  1  conversion in progress
- ovf  out  1  last captured t exceeded T_MAX
- dig_n  out  6  digit select, active low, bit i = digit i (0 = ms1)
- seg_n  out  7  segments gfedcba, active low
- dp_n  out  1  decimal point, active low

Behaviour:
- Reset: all outputs deasserted. bcd=0, bcd_valid=0, busy=0, ovf=0, dig_n=6'h3F, seg_n=7'h7F, dp_n=1. FSM in IDLE, scan index 0, divider 0, pending flag 0.
- time_1ms passes through a 2-flop synchronizer plus rising-edge detect, giving req, a one-clock pulse 3 clocks after the edge.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE + (req or pending): capture min(t, T_MAX) into the shift register, set ovf = (t > T_MAX), clear pending, busy=1, go to SHIFT.
  - SHIFT: exactly 20 cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts left 1 (combined in one cycle). After the 20th cycle go to DONE.
  - DONE: load bcd atomically, pulse bcd_valid, busy=0, return to IDLE.
- Latency: bcd_valid asserts 21 clocks after the capture cycle.
- req while busy sets pending (saturating, one deep). The conversion restarts from IDLE on the cycle after DONE, using t sampled at that moment. Extra requests are dropped.
- Scan: divider counts 0..SCAN_DIV-1; on wrap, index advances 0→5→0. Index and divider run continuously from reset, independent of the FSM.
- Guard cycle: on divider==0, dig_n=6'h3F (all off). Otherwise dig_n has only bit[index] low. seg_n/dp_n are registered with dig_n, so all outputs change on the same clock.
- Displayed digits always come from the registered bcd, so a half-converted value is never shown.
- Segment codes (seg_n): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Nibbles >9 are impossible; if one occurs, show 7F.
- dp_n=0 only while index==3.
- Blanking (BLANK_LZ=1): digit5 blanked if s100==0; digit4 blanked if s100==0 and s10==0. Digits 3..0 are never blanked. A blanked digit drives seg_n=7F; dig_n still cycles.
- ovf=1: display shows clamped 999.999; ovf stays set until the next capture of an in-range t.
- Reset mid-conversion: aborts immediately, pending is cleared, bcd returns to 0.

Test Plan:
- Reset, release, no strobe -> bcd=0. Display shows "  0.000": digit5/4 seg_n=7F; digit3 seg_n=40 with dp_n=0; digits 2..0 seg_n=40. Each digit has a 1-clock all-off guard.
- t=20'd123456, one time_1ms pulse -> busy for 21 clocks, then bcd_valid pulse. bcd=24'h123456. Scan shows digit5=79, digit4=24, digit3=30 with dp, digit2=19, digit1=12, digit0=02.
- t=20'd999999 then t=20'd1048575 -> first gives bcd=24'h999999, ovf=0; second gives bcd=24'h999999, ovf=1. A following t=7 gives bcd=24'h000007, ovf=0, digits 5/4 blanked.
- Second strobe 5 clocks into a conversion, t changed to 42 -> first conversion completes unchanged. Exactly one more conversion yields bcd=24'h000042. A third strobe during the same window causes no additional conversion.
- KEY2 low during SHIFT cycle 10 -> outputs reset within that clock. After release with no strobe, bcd stays 0 and no bcd_valid occurs.
- SCAN_DIV=4 -> each digit active 3 clocks plus 1 guard; index order 0..5, period 24 clocks; dp_n low only in index-3 window.
